// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard with EX operand forwarding select.
// Tracks outstanding loads per destination register and stalls decode on a dependent read.
module hazard_scoreboard #(
    parameter int FWD_STAGES = 3,
    parameter int MAX_OUT    = 4,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FWD_STAGES-1:0]   fwd_we,
    input  logic [5*FWD_STAGES-1:0] fwd_rd,
    input  logic [4:0]              ex_rs1,
    input  logic [4:0]              ex_rs2,
    output logic [1:0]              fwd_sel_1,
    output logic [1:0]              fwd_sel_2,
    input  logic [4:0]              id_rs1,
    input  logic [4:0]              id_rs2,
    input  logic [1:0]              id_rs_use,
    input  logic                    id_is_load,
    input  logic                    ex_load_issue,
    input  logic [4:0]              ex_load_rd,
    input  logic                    flush,
    input  logic                    mem_resp_valid,
    input  logic [4:0]              mem_resp_rd,
    output logic                    stall,
    output logic [CNT_W-1:0]        stall_cycles,
    output logic                    hazard_timeout,
    output logic                    spurious_resp
);
    localparam int OC_W = $clog2(MAX_OUT + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [31:0]           busy_reg, busy_next;
    logic [OC_W-1:0]       outcount_reg, outcount_next;
    logic [CNT_W-1:0]      stall_cycles_reg;
    logic [TO_W-1:0]       consec_reg;
    logic                  hazard_timeout_reg;
    logic                  spurious_resp_reg;
    logic [FWD_STAGES-1:0] match_1, match_2;
    logic                  load_acc, resp_ok, resp_spur;
    logic                  haz_1, haz_2, full_stall;

    genvar gi;
    generate
        for (gi = 0; gi < FWD_STAGES; gi++) begin : g_match
            assign match_1[gi] = fwd_we[gi] && (fwd_rd[5*gi +: 5] != 5'd0) && (fwd_rd[5*gi +: 5] == ex_rs1);
            assign match_2[gi] = fwd_we[gi] && (fwd_rd[5*gi +: 5] != 5'd0) && (fwd_rd[5*gi +: 5] == ex_rs2);
        end
    endgenerate

    // Scan from the far stage down so the stage nearest EX takes priority.
    always_comb begin
        fwd_sel_1 = 2'd0;
        fwd_sel_2 = 2'd0;
        for (int i = FWD_STAGES - 1; i >= 0; i--) begin
            if (match_1[i]) fwd_sel_1 = 2'(i + 1);
            if (match_2[i]) fwd_sel_2 = 2'(i + 1);
        end
    end

    assign load_acc  = ex_load_issue && !flush && (ex_load_rd != 5'd0);
    assign resp_ok   = mem_resp_valid && (outcount_reg != '0);
    assign resp_spur = mem_resp_valid && (outcount_reg == '0);

    // Clear first, then set, so a same-cycle set on the same register wins.
    always_comb begin
        busy_next = busy_reg;
        if (resp_ok)  busy_next[mem_resp_rd] = 1'b0;
        if (load_acc) busy_next[ex_load_rd]  = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        outcount_next = outcount_reg;
        if (load_acc && !resp_ok) begin
            if (outcount_reg != OC_W'(MAX_OUT)) outcount_next = outcount_reg + OC_W'(1);
        end else if (!load_acc && resp_ok) begin
            outcount_next = outcount_reg - OC_W'(1);
        end
    end

    // A returning load's data is forwarded, so its register no longer blocks this cycle.
    assign haz_1 = id_rs_use[0] && (id_rs1 != 5'd0) &&
                   ((busy_reg[id_rs1] && !(mem_resp_valid && mem_resp_rd == id_rs1)) ||
                    (ex_load_issue && !flush && ex_load_rd == id_rs1));
    assign haz_2 = id_rs_use[1] && (id_rs2 != 5'd0) &&
                   ((busy_reg[id_rs2] && !(mem_resp_valid && mem_resp_rd == id_rs2)) ||
                    (ex_load_issue && !flush && ex_load_rd == id_rs2));
    assign full_stall = id_is_load && (outcount_reg == OC_W'(MAX_OUT)) && !mem_resp_valid;
    assign stall      = !rst && (haz_1 || haz_2 || full_stall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg           <= '0;
            outcount_reg       <= '0;
            stall_cycles_reg   <= '0;
            consec_reg         <= '0;
            hazard_timeout_reg <= 1'b0;
            spurious_resp_reg  <= 1'b0;
        end else begin
            busy_reg     <= busy_next;
            outcount_reg <= outcount_next;
            if (stall) begin
                if (stall_cycles_reg != '1) stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
                if (consec_reg != TO_W'(TIMEOUT)) consec_reg <= consec_reg + TO_W'(1);
                if (consec_reg == TO_W'(TIMEOUT - 1)) hazard_timeout_reg <= 1'b1;
            end else begin
                consec_reg <= '0;
            end
            if (resp_spur) spurious_resp_reg <= 1'b1;
        end
    end

    assign stall_cycles   = stall_cycles_reg;
    assign hazard_timeout = hazard_timeout_reg;
    assign spurious_resp  = spurious_resp_reg;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: forwarding vector table plus cycle sequences for loads,
// flush, occupancy limit, timeout and mid-run reset.
module tb_hazard_scoreboard;
    localparam int FS = 3;
    localparam int MO = 4;
    localparam int TO = 8;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [FS-1:0]   fwd_we = '0;
    logic [5*FS-1:0] fwd_rd = '0;
    logic [4:0]      ex_rs1 = '0, ex_rs2 = '0;
    logic [1:0]      fwd_sel_1, fwd_sel_2;
    logic [4:0]      id_rs1 = '0, id_rs2 = '0;
    logic [1:0]      id_rs_use = '0;
    logic            id_is_load = 1'b0;
    logic            ex_load_issue = 1'b0;
    logic [4:0]      ex_load_rd = '0;
    logic            flush = 1'b0;
    logic            mem_resp_valid = 1'b0;
    logic [4:0]      mem_resp_rd = '0;
    logic            stall;
    logic [CW-1:0]   stall_cycles;
    logic            hazard_timeout, spurious_resp;

    hazard_scoreboard #(.FWD_STAGES(FS), .MAX_OUT(MO), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .fwd_we(fwd_we), .fwd_rd(fwd_rd),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs_use(id_rs_use), .id_is_load(id_is_load),
        .ex_load_issue(ex_load_issue), .ex_load_rd(ex_load_rd), .flush(flush),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rd(mem_resp_rd), .stall(stall),
        .stall_cycles(stall_cycles), .hazard_timeout(hazard_timeout), .spurious_resp(spurious_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    typedef struct {
        logic [2:0]  we;
        logic [14:0] rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  e1;
        logic [1:0]  e2;
    } fwd_vec_t;

    exp_t     sb_q[$];
    fwd_vec_t fv[7];
    int       total = 0;
    int       bad = 0;
    int       exp_sc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic push(input string name, input logic [31:0] exp);
        sb_q.push_back('{name: name, exp: exp});
    endtask

    task automatic pop_check(input logic [31:0] act);
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got %0d expected an entry", act);
        end else begin
            e = sb_q.pop_front();
            chk(e.name, act, e.exp);
        end
    endtask

    task automatic set_idle();
        id_rs1 = '0; id_rs2 = '0; id_rs_use = '0; id_is_load = 1'b0;
        ex_load_issue = 1'b0; ex_load_rd = '0; flush = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_rd = '0;
    endtask

    // Inputs are already driven; check stall mid-cycle, then advance past the next edge.
    task automatic step(input string name, input logic exp_stall);
        push(name, {31'd0, exp_stall});
        @(negedge clk);
        pop_check({31'd0, stall});
        if (exp_stall) exp_sc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fv[0] = '{3'b111, {5'd5, 5'd5, 5'd5}, 5'd5, 5'd0, 2'd1, 2'd0};
        fv[1] = '{3'b110, {5'd5, 5'd5, 5'd5}, 5'd5, 5'd5, 2'd2, 2'd2};
        fv[2] = '{3'b111, {5'd5, 5'd5, 5'd5}, 5'd0, 5'd0, 2'd0, 2'd0};
        fv[3] = '{3'b111, {5'd0, 5'd0, 5'd0}, 5'd0, 5'd0, 2'd0, 2'd0};
        fv[4] = '{3'b100, {5'd5, 5'd3, 5'd3}, 5'd5, 5'd3, 2'd3, 2'd0};
        fv[5] = '{3'b011, {5'd9, 5'd4, 5'd9}, 5'd9, 5'd4, 2'd1, 2'd2};
        fv[6] = '{3'b111, {5'd2, 5'd2, 5'd8}, 5'd2, 5'd8, 2'd2, 2'd1};

        // Reset, with a would-be hazard driven to show stall stays low.
        #2 rst = 1'b1;
        ex_load_issue = 1'b1; ex_load_rd = 5'd3; id_rs1 = 5'd3; id_rs_use = 2'b01;
        @(negedge clk);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_stall_cycles", 32'(stall_cycles), 32'd0);
        chk("reset_timeout", {31'd0, hazard_timeout}, 32'd0);
        chk("reset_spurious", {31'd0, spurious_resp}, 32'd0);
        set_idle();
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            fwd_we = fv[i].we; fwd_rd = fv[i].rd; ex_rs1 = fv[i].rs1; ex_rs2 = fv[i].rs2;
            push($sformatf("fwd_sel_1_vec%0d", i), 32'(fv[i].e1));
            push($sformatf("fwd_sel_2_vec%0d", i), 32'(fv[i].e2));
            #1;
            pop_check(32'(fwd_sel_1));
            pop_check(32'(fwd_sel_2));
        end
        fwd_we = '0;
        @(posedge clk);
        #1;

        // Load x7 with dependent rs1; response in cycle 3.
        set_idle();
        ex_load_issue = 1'b1; ex_load_rd = 5'd7; id_rs1 = 5'd7; id_rs_use = 2'b01;
        step("a_c0_issue", 1'b1);
        ex_load_issue = 1'b0;
        step("a_c1_busy", 1'b1);
        step("a_c2_busy", 1'b1);
        mem_resp_valid = 1'b1; mem_resp_rd = 5'd7;
        step("a_c3_resp", 1'b0);
        mem_resp_valid = 1'b0;
        step("a_c4_cleared", 1'b0);
        chk("a_stall_cycles", 32'(stall_cycles), 32'd3);

        // Unused rs2 must not stall.
        set_idle();
        ex_load_issue = 1'b1; ex_load_rd = 5'd7;
        step("b_issue", 1'b0);
        ex_load_issue = 1'b0; id_rs2 = 5'd7; id_rs_use = 2'b01;
        step("b_rs2_unused", 1'b0);
        id_rs_use = 2'b10;
        step("b_rs2_used", 1'b1);
        mem_resp_valid = 1'b1; mem_resp_rd = 5'd7;
        step("b_resp", 1'b0);

        // Fill to MAX_OUT, then a decode load stalls unless a response arrives.
        set_idle();
        for (int k = 1; k <= 4; k++) begin
            ex_load_issue = 1'b1; ex_load_rd = 5'(k);
            step($sformatf("c_issue_x%0d", k), 1'b0);
        end
        ex_load_issue = 1'b0; id_is_load = 1'b1;
        step("c_full", 1'b1);
        mem_resp_valid = 1'b1; mem_resp_rd = 5'd1;
        step("c_full_resp", 1'b0);
        mem_resp_valid = 1'b0;
        step("c_three_out", 1'b0);
        id_is_load = 1'b0; mem_resp_valid = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            mem_resp_rd = 5'(k);
            step($sformatf("c_drain_x%0d", k), 1'b0);
        end
        mem_resp_valid = 1'b0;
        chk("c_no_spurious", {31'd0, spurious_resp}, 32'd0);

        // Same-cycle set and clear of x11: set wins, occupancy unchanged.
        set_idle();
        ex_load_issue = 1'b1; ex_load_rd = 5'd11;
        step("s_issue", 1'b0);
        mem_resp_valid = 1'b1; mem_resp_rd = 5'd11;
        step("s_set_clear", 1'b0);
        set_idle(); id_rs1 = 5'd11; id_rs_use = 2'b01;
        step("s_busy_kept", 1'b1);
        mem_resp_valid = 1'b1; mem_resp_rd = 5'd11;
        step("s_resp", 1'b0);
        mem_resp_valid = 1'b0;
        step("s_cleared", 1'b0);
        chk("s_no_spurious", {31'd0, spurious_resp}, 32'd0);
        chk("s_stall_cycles", 32'(stall_cycles), 32'(exp_sc));

        // Flushed load is never accepted; its response is spurious.
        set_idle();
        ex_load_issue = 1'b1; ex_load_rd = 5'd9; flush = 1'b1; id_rs1 = 5'd9; id_rs_use = 2'b01;
        step("d_flush_issue", 1'b0);
        ex_load_issue = 1'b0; flush = 1'b0;
        step("d_not_busy", 1'b0);
        chk("d_before_resp", {31'd0, spurious_resp}, 32'd0);
        mem_resp_valid = 1'b1; mem_resp_rd = 5'd9; id_rs_use = 2'b00;
        step("d_spur_resp", 1'b0);
        set_idle();
        chk("d_spurious", {31'd0, spurious_resp}, 32'd1);
        step("d_idle", 1'b0);
        chk("d_spurious_sticky", {31'd0, spurious_resp}, 32'd1);

        // Flush after acceptance keeps the register busy.
        ex_load_issue = 1'b1; ex_load_rd = 5'd5;
        step("e_issue", 1'b0);
        ex_load_issue = 1'b0; flush = 1'b1; id_rs1 = 5'd5; id_rs_use = 2'b01;
        step("e_flush_keeps", 1'b1);
        flush = 1'b0; mem_resp_valid = 1'b1; mem_resp_rd = 5'd5;
        step("e_resp", 1'b0);

        // Eight consecutive stalls raise the sticky timeout.
        set_idle();
        ex_load_issue = 1'b1; ex_load_rd = 5'd6; id_rs1 = 5'd6; id_rs_use = 2'b01;
        step("t_c0", 1'b1);
        ex_load_issue = 1'b0;
        for (int k = 1; k <= 6; k++) step($sformatf("t_c%0d", k), 1'b1);
        chk("t_not_yet", {31'd0, hazard_timeout}, 32'd0);
        step("t_c7", 1'b1);
        chk("t_timeout", {31'd0, hazard_timeout}, 32'd1);
        mem_resp_valid = 1'b1; mem_resp_rd = 5'd6;
        step("t_resp", 1'b0);
        set_idle();
        step("t_idle", 1'b0);
        chk("t_timeout_sticky", {31'd0, hazard_timeout}, 32'd1);
        chk("t_stall_cycles", 32'(stall_cycles), 32'(exp_sc));

        // Reset mid-operation drops the outstanding x10 load.
        ex_load_issue = 1'b1; ex_load_rd = 5'd10;
        step("r_issue", 1'b0);
        ex_load_issue = 1'b0;
        #2 rst = 1'b1;
        exp_sc = 0;
        @(negedge clk);
        chk("r_timeout_clr", {31'd0, hazard_timeout}, 32'd0);
        chk("r_spurious_clr", {31'd0, spurious_resp}, 32'd0);
        chk("r_stall_cycles_clr", 32'(stall_cycles), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        id_rs1 = 5'd10; id_rs_use = 2'b01;
        step("r_discarded", 1'b0);
        id_rs_use = 2'b00; mem_resp_valid = 1'b1; mem_resp_rd = 5'd10;
        step("r_late_resp", 1'b0);
        set_idle();
        chk("r_spurious", {31'd0, spurious_resp}, 32'd1);
        chk("r_stall_cycles", 32'(stall_cycles), 32'(exp_sc));

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
